// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: Moore FSM sequencing a shared-memory multi-cycle RISC-V datapath.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   op, f3                   opcode / funct3 from IR
//   zero, sign_bit           ALU flags from the current cycle (branch resolution)
//   mem_ready                memory access completes this cycle
//   pc_we, old_pc_we, ir_we  PC / oldPC / IR load strobes
//   adr_sel, mem_re, mem_we  memory address select (0=PC, 1=ALUOut) and request strobes
//   reg_we                   register file write
//   alu_src_a, alu_src_b     ALU operand selects
//   alu_op, imm_sel          ALU operation, immediate format
//   result_sel, slt_sel      write-back source, SLT sign extraction
//   illegal                  undefined-opcode pulse in DECODE
//   state_o                  current state (debug)
module multi_cycle_controller #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] f3,
   input  logic       zero,
   input  logic       sign_bit,
   input  logic       mem_ready,
   output logic       pc_we,
   output logic       old_pc_we,
   output logic       ir_we,
   output logic       adr_sel,
   output logic       mem_re,
   output logic       mem_we,
   output logic       reg_we,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [2:0] imm_sel,
   output logic [1:0] result_sel,
   output logic       slt_sel,
   output logic       illegal,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      EXEC_R  = 4'd2,
      EXEC_I  = 4'd3,
      ALU_WB  = 4'd4,
      MEM_ADR = 4'd5,
      MEM_RD  = 4'd6,
      MEM_WB  = 4'd7,
      MEM_WR  = 4'd8,
      BRANCH  = 4'd9,
      JAL     = 4'd10,
      JALR    = 4'd11,
      JALR_WB = 4'd12,
      LUI     = 4'd13
   } stateT;

   localparam logic [6:0] OP_R    = 7'd0;
   localparam logic [6:0] OP_LW   = 7'd1;
   localparam logic [6:0] OP_ADDI = 7'd2;
   localparam logic [6:0] OP_XORI = 7'd3;
   localparam logic [6:0] OP_ORI  = 7'd4;
   localparam logic [6:0] OP_SLTI = 7'd5;
   localparam logic [6:0] OP_JALR = 7'd6;
   localparam logic [6:0] OP_SW   = 7'd7;
   localparam logic [6:0] OP_JAL  = 7'd8;
   localparam logic [6:0] OP_BEQ  = 7'd9;
   localparam logic [6:0] OP_BNE  = 7'd10;
   localparam logic [6:0] OP_BLT  = 7'd11;
   localparam logic [6:0] OP_BGE  = 7'd12;
   localparam logic [6:0] OP_LUI  = 7'd13;

   stateT state, nextState;
   logic  taken;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= stateT'(RESET_STATE);
      else     state <= nextState;

   assign state_o = state;

   assign taken = (op == OP_BEQ) ? zero :
                  (op == OP_BNE) ? ~zero :
                  (op == OP_BLT) ? sign_bit :
                  (op == OP_BGE) ? ~sign_bit : 1'b0;

   // Everything is forced low while rst is high, so an abandoned access drops at once.
   always_comb begin
      nextState  = FETCH;
      pc_we      = 1'b0;
      old_pc_we  = 1'b0;
      ir_we      = 1'b0;
      adr_sel    = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 3'b000;
      imm_sel    = 3'b000;
      result_sel = 2'b00;
      slt_sel    = 1'b0;
      illegal    = 1'b0;
      if (!rst) begin
         case (state)
            FETCH: begin
               mem_re    = 1'b1;
               alu_src_b = 2'b10;
               pc_we     = mem_ready;
               old_pc_we = mem_ready;
               ir_we     = mem_ready;
               nextState = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b01;
               imm_sel   = 3'b010;
               case (op)
                  OP_R:                            nextState = EXEC_R;
                  OP_ADDI, OP_XORI, OP_ORI, OP_SLTI: nextState = EXEC_I;
                  OP_LW, OP_SW:                    nextState = MEM_ADR;
                  OP_JAL:                          nextState = JAL;
                  OP_JALR:                         nextState = JALR;
                  OP_BEQ, OP_BNE, OP_BLT, OP_BGE:  nextState = BRANCH;
                  OP_LUI:                          nextState = LUI;
                  default:                         illegal   = 1'b1;
               endcase
            end
            EXEC_R: begin
               alu_src_a = 2'b10;
               alu_op    = f3;
               nextState = ALU_WB;
            end
            EXEC_I: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
               alu_op    = (op == OP_XORI) ? 3'b010 :
                           (op == OP_ORI)  ? 3'b011 :
                           (op == OP_SLTI) ? 3'b001 : 3'b000;
               nextState = ALU_WB;
            end
            ALU_WB: begin
               reg_we  = 1'b1;
               slt_sel = (op == OP_SLTI);
            end
            MEM_ADR: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
               imm_sel   = (op == OP_SW) ? 3'b001 : 3'b000;
               nextState = (op == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
               adr_sel   = 1'b1;
               mem_re    = 1'b1;
               nextState = mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
               reg_we     = 1'b1;
               result_sel = 2'b01;
            end
            MEM_WR: begin
               adr_sel   = 1'b1;
               mem_we    = 1'b1;
               nextState = mem_ready ? FETCH : MEM_WR;
            end
            BRANCH: begin
               alu_src_a = 2'b10;
               alu_op    = 3'b001;
               pc_we     = taken;
            end
            // JAL and JALR_WB: rd <= oldPC+4 straight from the ALU while PC takes ALUOut.
            JAL, JALR_WB: begin
               reg_we     = 1'b1;
               pc_we      = 1'b1;
               result_sel = 2'b10;
               alu_src_a  = 2'b01;
               alu_src_b  = 2'b10;
            end
            JALR: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
               nextState = JALR_WB;
            end
            LUI: begin
               reg_we     = 1'b1;
               result_sel = 2'b11;
               imm_sel    = 3'b100;
            end
            default: nextState = FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: directed and randomized instruction streams against a phase-list reference model.
module tb_multi_cycle_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] f3;
   logic       zero, sign_bit, mem_ready;
   logic       pc_we, old_pc_we, ir_we, adr_sel, mem_re, mem_we, reg_we;
   logic [1:0] alu_src_a, alu_src_b, result_sel;
   logic [2:0] alu_op, imm_sel;
   logic       slt_sel, illegal;
   logic [3:0] state_o;
   logic [20:0] ctrl;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   multi_cycle_controller dut (
      .clk(clk), .rst(rst), .op(op), .f3(f3), .zero(zero), .sign_bit(sign_bit),
      .mem_ready(mem_ready), .pc_we(pc_we), .old_pc_we(old_pc_we), .ir_we(ir_we),
      .adr_sel(adr_sel), .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel),
      .result_sel(result_sel), .slt_sel(slt_sel), .illegal(illegal), .state_o(state_o)
   );

   assign ctrl = {pc_we, old_pc_we, ir_we, adr_sel, mem_re, mem_we, reg_we,
                  alu_src_a, alu_src_b, alu_op, imm_sel, result_sel, slt_sel, illegal};

   // Control word each phase of an instruction must present, straight from the datapath's needs.
   function automatic logic [20:0] expCtrl(input int p, input logic [6:0] o, input logic [2:0] f,
                                           input logic z, input logic s, input logic rdy);
      logic pcW, oldW, irW, adr, re, we, rw, slt, ill;
      logic [1:0] a, b, rs;
      logic [2:0] alu, imm;
      logic tk;
      {pcW, oldW, irW, adr, re, we, rw, slt, ill} = '0;
      {a, b, rs, alu, imm} = '0;
      tk = (o == 9 && z) || (o == 10 && !z) || (o == 11 && s) || (o == 12 && !s);
      case (p)
         0:  begin re = 1; b = 2; {pcW, oldW, irW} = {3{rdy}}; end
         1:  begin a = 1; b = 1; imm = 3'd2; ill = (o > 13); end
         2:  begin a = 2; alu = f; end
         3:  begin a = 2; b = 1; alu = (o == 3) ? 3'd2 : (o == 4) ? 3'd3 : (o == 5) ? 3'd1 : 3'd0; end
         4:  begin rw = 1; slt = (o == 5); end
         5:  begin a = 2; b = 1; imm = (o == 7) ? 3'd1 : 3'd0; end
         6:  begin adr = 1; re = 1; end
         7:  begin rw = 1; rs = 1; end
         8:  begin adr = 1; we = 1; end
         9:  begin a = 2; alu = 3'd1; pcW = tk; end
         10, 12: begin rw = 1; pcW = 1; rs = 2; a = 1; b = 2; end
         11: begin a = 2; b = 1; end
         13: begin rw = 1; rs = 3; imm = 3'd4; end
         default: ;
      endcase
      return {pcW, oldW, irW, adr, re, we, rw, a, b, alu, imm, rs, slt, ill};
   endfunction

   task automatic checkAll(input int p, input string tag);
      logic [20:0] e;
      e = expCtrl(p, op, f3, zero, sign_bit, mem_ready);
      compared++;
      assert (state_o === 4'(p)) else begin
         mismatched++;
         $error("FAIL %s state observed=%0d expected=%0d", tag, state_o, p);
      end
      compared++;
      assert (ctrl === e) else begin
         mismatched++;
         $error("FAIL %s ctrl state=%0d observed=%h expected=%h", tag, p, ctrl, e);
      end
   endtask

   // One phase; memory phases (0, 6, 8) stall for 'waits' cycles before completing.
   task automatic doPhase(input int p, input int waits, input string tag);
      for (int k = 0; k <= waits; k++) begin
         mem_ready = (p == 0 || p == 6 || p == 8) ? (k == waits) : 1'($urandom_range(0, 1));
         @(negedge clk);
         checkAll(p, tag);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic runInstr(input logic [6:0] o, input logic [2:0] f, input logic z, input logic s,
                           input int fs, input int ds, input string tag);
      int q[$];
      op = o; f3 = f; zero = z; sign_bit = s;
      if (o == 0)                   q = {0, 1, 2, 4};
      else if (o inside {[2:5]})    q = {0, 1, 3, 4};
      else if (o == 1)              q = {0, 1, 5, 6, 7};
      else if (o == 7)              q = {0, 1, 5, 8};
      else if (o inside {[9:12]})   q = {0, 1, 9};
      else if (o == 8)              q = {0, 1, 10};
      else if (o == 6)              q = {0, 1, 11, 12};
      else if (o == 13)             q = {0, 1, 13};
      else                          q = {0, 1};
      foreach (q[i]) doPhase(q[i], (q[i] == 0) ? fs : (q[i] == 6 || q[i] == 8) ? ds : 0, tag);
   endtask

   initial begin
      logic [6:0] o;
      rst = 1'b1; op = '0; f3 = '0; zero = 1'b0; sign_bit = 1'b0; mem_ready = 1'b1;
      #2;
      compared++;
      assert (state_o === 4'd0) else begin mismatched++; $error("FAIL reset state observed=%0d expected=0", state_o); end
      compared++;
      assert (ctrl === 21'd0) else begin mismatched++; $error("FAIL reset ctrl observed=%h expected=0", ctrl); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // T1: SW stalled in MEM_WR, then reset drops mem_we without waiting for a clock.
      op = 7'd7; f3 = '0;
      doPhase(0, 0, "t1_sw");
      doPhase(1, 0, "t1_sw");
      doPhase(5, 0, "t1_sw");
      mem_ready = 1'b0;
      @(negedge clk);
      checkAll(8, "t1_stall");
      #2 rst = 1'b1;
      #1;
      compared++;
      assert (mem_we === 1'b0) else begin mismatched++; $error("FAIL t1_async mem_we observed=%b expected=0", mem_we); end
      compared++;
      assert (state_o === 4'd0) else begin mismatched++; $error("FAIL t1_async state observed=%0d expected=0", state_o); end
      compared++;
      assert (ctrl === 21'd0) else begin mismatched++; $error("FAIL t1_async ctrl observed=%h expected=0", ctrl); end
      @(posedge clk);
      #1 rst = 1'b0;

      runInstr(7'd2,  3'd0, 1'b0, 1'b0, 0, 0, "t2_addi");
      runInstr(7'd1,  3'd2, 1'b0, 1'b0, 0, 3, "t3_lw");
      runInstr(7'd11, 3'd4, 1'b0, 1'b1, 0, 0, "t4_blt_taken");
      runInstr(7'd11, 3'd4, 1'b0, 1'b0, 0, 0, "t4_blt_not");
      runInstr(7'd10, 3'd1, 1'b1, 1'b0, 0, 0, "t4_bne_not");
      runInstr(7'd7,  3'd2, 1'b0, 1'b0, 0, 2, "t5_sw");
      runInstr(7'd20, 3'd0, 1'b0, 1'b0, 0, 0, "t6_illegal");
      runInstr(7'd0,  3'd6, 1'b0, 1'b0, 2, 0, "r_type");
      runInstr(7'd5,  3'd2, 1'b0, 1'b0, 1, 0, "slti");
      runInstr(7'd6,  3'd0, 1'b0, 1'b0, 0, 0, "jalr");
      runInstr(7'd8,  3'd0, 1'b0, 1'b0, 0, 0, "jal");
      runInstr(7'd13, 3'd0, 1'b0, 1'b0, 0, 0, "lui");

      repeat (80) begin
         o = ($urandom_range(0, 15) < 14) ? 7'($urandom_range(0, 13)) : 7'($urandom_range(14, 127));
         runInstr(o, 3'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2), $urandom_range(0, 3), "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
